// File: rtl/keypad_scan_if.sv
// Keypad scan controller bundle: matrix pins, debouncer hand-off and code buffer.
// The master side is the controller; the slave side is the keypad, debouncer and consumer.
interface keypad_scan_if #(
  parameter int N_DIGITS = 4
);
  logic [3:0]            col_in;
  logic [3:0]            row_out;
  logic                  deb_btn;
  logic [3:0]            deb_data;
  logic                  deb_pulse;
  logic                  key_stb;
  logic [3:0]            key_code;
  logic [4*N_DIGITS-1:0] code;
  logic [2:0]            code_len;
  logic                  code_ready;
  logic                  code_ack;

  modport master (
    input  col_in, deb_pulse, code_ack,
    output row_out, deb_btn, deb_data, key_stb, key_code, code, code_len, code_ready
  );

  modport slave (
    output col_in, deb_pulse, code_ack,
    input  row_out, deb_btn, deb_data, key_stb, key_code, code, code_len, code_ready
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner: locks onto one pressed key, hands it to the debouncer,
// waits for release and assembles accepted digits into a BCD code buffer.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 5000,
  parameter int SETTLE   = 16,
  parameter int REL_CYC  = 4000,
  parameter int N_DIGITS = 4
) (
  input  logic           clk,
  input  logic           reset,
  keypad_scan_if.master  kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(REL_CYC + 1);
  localparam int CW = 4 * N_DIGITS;

  // Indexed by {row, col}; row 3 holds * (E), 0, # (F), D.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  typedef enum logic [1:0] {SCAN, PRESS, ACCEPT, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    row_q;
  logic [DW-1:0] cnt_q;
  logic [RW-1:0] rel_q;
  logic [1:0]    col_q;
  logic [3:0]    key_q;
  logic          deb_btn_q;
  logic [3:0]    key_code_q;
  logic [CW-1:0] code_q;
  logic [2:0]    len_q;
  logic          ready_q;

  logic [3:0]    low;
  logic          one_low;
  logic [1:0]    col_hit;
  logic          lat_high, all_high, scan_end, rel_done;
  logic [CW+3:0] code_shift;

  assign low      = ~kp.col_in;
  assign one_low  = (low != 4'h0) && ((low & (low - 4'd1)) == 4'h0);
  assign lat_high = kp.col_in[col_q];
  assign all_high = (kp.col_in == 4'hF);
  assign scan_end = (cnt_q == DW'(SCAN_DIV - 1));
  assign rel_done = (rel_q == RW'(REL_CYC - 1));
  assign code_shift = {code_q, key_q};

  always_comb begin
    col_hit = 2'd0;
    for (int i = 0; i < 4; i++)
      if (low[i]) col_hit = i[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SCAN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (cnt_q >= DW'(SETTLE) && one_low) state_d = PRESS;
      PRESS:   if (kp.deb_pulse)             state_d = ACCEPT;
               else if (lat_high && rel_done) state_d = RELEASE;
      ACCEPT:  state_d = RELEASE;
      RELEASE: if (all_high && rel_done)      state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  // Scan position, latched key and release qualification.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q      <= 2'd0;
      cnt_q      <= '0;
      rel_q      <= '0;
      col_q      <= 2'd0;
      key_q      <= 4'hF;
      deb_btn_q  <= 1'b0;
      key_code_q <= 4'h0;
    end else begin
      deb_btn_q <= 1'b0;
      case (state_q)
        SCAN: begin
          rel_q <= '0;
          if (state_d == PRESS) begin
            col_q     <= col_hit;
            key_q     <= KEYMAP[{row_q, col_hit}];
            deb_btn_q <= 1'b1;
          end else if (scan_end) begin
            row_q <= row_q + 2'd1;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end
        PRESS: begin
          if (state_d == PRESS) begin
            deb_btn_q <= ~lat_high;
            rel_q     <= lat_high ? rel_q + RW'(1) : '0;
          end else begin
            rel_q <= '0;
          end
          if (kp.deb_pulse) key_code_q <= key_q;
        end
        ACCEPT: rel_q <= '0;
        RELEASE: begin
          if (state_d == SCAN) begin
            row_q <= row_q + 2'd1;
            cnt_q <= '0;
            rel_q <= '0;
          end else begin
            rel_q <= all_high ? rel_q + RW'(1) : '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Code buffer: an ack always wins; a ready buffer only listens for '*'.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q  <= '0;
      len_q   <= 3'd0;
      ready_q <= 1'b0;
    end else if (kp.code_ack) begin
      code_q  <= '0;
      len_q   <= 3'd0;
      ready_q <= 1'b0;
    end else if (state_q == ACCEPT) begin
      if (ready_q) begin
        if (key_q == 4'hE) begin
          code_q  <= '0;
          len_q   <= 3'd0;
          ready_q <= 1'b0;
        end
      end else if (key_q == 4'hE) begin
        code_q <= '0;
        len_q  <= 3'd0;
      end else if (key_q == 4'hF) begin
        if (len_q != 3'd0) ready_q <= 1'b1;
      end else if (key_q <= 4'h9 && len_q < 3'(N_DIGITS)) begin
        code_q <= code_shift[CW-1:0];
        len_q  <= len_q + 3'd1;
      end
    end
  end

  assign kp.row_out    = ~(4'b0001 << row_q);
  assign kp.deb_btn    = deb_btn_q;
  assign kp.deb_data   = key_q;
  assign kp.key_stb    = (state_q == ACCEPT);
  assign kp.key_code   = key_code_q;
  assign kp.code       = code_q;
  assign kp.code_len   = len_q;
  assign kp.code_ready = ready_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: key matrix model, behavioural debouncer,
// hand-computed expectations for scan, buffer, ghost, bounce and reset cases.
module tb_keypad_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_if #(.N_DIGITS(4)) kif();

  keypad_scan_ctrl #(.SCAN_DIV(8), .SETTLE(2), .REL_CYC(4), .N_DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif.master)
  );

  // Key matrix: bit r*4+c pressed pulls col c low while row r is driven low.
  logic [15:0] kmask = '0;
  logic [3:0]  col_v;
  always_comb begin
    col_v = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (kmask[r*4+c] && !kif.row_out[r]) col_v[c] = 1'b0;
  end
  assign kif.col_in = col_v;

  // Debouncer stand-in: one pulse after deb_btn has been high three clocks.
  logic deb_en = 1'b1;
  logic deb_pulse_r = 1'b0;
  int   dcnt = 0;
  always @(posedge clk) begin
    if (kif.deb_btn) begin
      dcnt        <= dcnt + 1;
      deb_pulse_r <= deb_en && (dcnt == 2);
    end else begin
      dcnt        <= 0;
      deb_pulse_r <= 1'b0;
    end
  end
  assign kif.deb_pulse = deb_pulse_r;

  int stb_cnt = 0;
  always @(negedge clk) if (kif.key_stb) stb_cnt <= stb_cnt + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic       saw_btn;
  logic [3:0] btn_data;
  logic [3:0] kc;

  task automatic press_key(input int r, input int c, input int hold);
    bit got;
    got = 0;
    saw_btn = 0;
    btn_data = 4'hF;
    kmask[r*4+c] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (kif.deb_btn && !saw_btn) begin
        saw_btn = 1;
        btn_data = kif.deb_data;
      end
      if (kif.key_stb) begin
        got = 1;
        kc = kif.key_code;
      end
    end
    if (!got) chk("press_timeout", 0, 1);
    repeat (hold) @(negedge clk);
  endtask

  task automatic release_all();
    kmask = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic ack();
    kif.code_ack = 1'b1;
    @(negedge clk);
    kif.code_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic key(input int r, input int c);
    press_key(r, c, 0);
    release_all();
  endtask

  logic [3:0] exp_rows [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int         base;
  logic [3:0] visited;
  bit         btn_seen, ok;

  initial begin
    kif.code_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_row", kif.row_out, 4'b1110);
    chk("rst_btn", kif.deb_btn, 0);
    chk("rst_data", kif.deb_data, 4'hF);
    chk("rst_stb", kif.key_stb, 0);
    chk("rst_code", {kif.code_ready, kif.code_len, kif.code}, 0);
    reset = 1'b0;

    // Idle scan: each row held 8 clocks
    for (int k = 0; k < 5; k++) begin
      chk("idle_row", kif.row_out, exp_rows[k]);
      if (k == 0) begin
        repeat (7) @(negedge clk);
        chk("idle_row0_hold", kif.row_out, 4'b1110);
        @(negedge clk);
      end else repeat (8) @(negedge clk);
    end

    // Single key '5'
    base = stb_cnt;
    press_key(1, 1, 0);
    chk("k5_btn", saw_btn, 1);
    chk("k5_data", btn_data, 4'h5);
    chk("k5_code", kc, 4'h5);
    release_all();
    chk("k5_stb", stb_cnt - base, 1);
    chk("k5_buf", kif.code, 16'h0005);
    chk("k5_len", kif.code_len, 1);
    ack();

    // Fill buffer: 1 2 3 4, then 7 overflows
    base = stb_cnt;
    key(0, 0); key(0, 1); key(0, 2); key(1, 0); key(2, 0);
    chk("fill_stb", stb_cnt - base, 5);
    chk("fill_kc", kif.key_code, 4'h7);
    chk("fill_buf", kif.code, 16'h1234);
    chk("fill_len", kif.code_len, 4);
    key(3, 2);
    chk("hash_rdy", kif.code_ready, 1);
    key(2, 2);
    chk("rdy_9_buf", kif.code, 16'h1234);
    chk("rdy_9_len", kif.code_len, 4);
    chk("rdy_9_rdy", kif.code_ready, 1);
    ack();
    chk("ack_clr", {kif.code_ready, kif.code_len, kif.code}, 0);

    // Ghost: two columns low in row 0
    base = stb_cnt;
    visited = '0;
    btn_seen = 0;
    kmask = 16'h0003;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      visited |= ~kif.row_out;
      if (kif.deb_btn) btn_seen = 1;
    end
    kmask = '0;
    chk("ghost_btn", btn_seen, 0);
    chk("ghost_scan", visited, 4'hF);
    chk("ghost_stb", stb_cnt - base, 0);

    // Long hold of '8', then bounce on release
    base = stb_cnt;
    press_key(2, 1, 100);
    kmask = '0;
    repeat (2) @(negedge clk);
    kmask[9] = 1'b1;
    repeat (2) @(negedge clk);
    kmask = '0;
    repeat (3) @(negedge clk);
    chk("bounce_hold_row", kif.row_out, 4'b1011);
    @(negedge clk);
    chk("bounce_resume_row", kif.row_out, 4'b0111);
    repeat (4) @(negedge clk);
    chk("hold_stb", stb_cnt - base, 1);
    chk("hold_buf", kif.code, 16'h0008);

    // Reset while parked in PRESS
    deb_en = 1'b0;
    kmask[2] = 1'b1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (kif.deb_btn) ok = 1;
    end
    chk("prs_reach", ok, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_row", kif.row_out, 4'b1110);
    chk("arst_btn", kif.deb_btn, 0);
    chk("arst_data", kif.deb_data, 4'hF);
    chk("arst_kc", kif.key_code, 0);
    chk("arst_buf", {kif.code_ready, kif.code_len, kif.code}, 0);
    kmask = '0;
    deb_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // '#' on empty buffer, '*' mid-entry, letter key, '*' on ready
    key(3, 2);
    chk("empty_hash_kc", kif.key_code, 4'hF);
    chk("empty_hash_rdy", kif.code_ready, 0);
    key(0, 0); key(0, 1);
    chk("pre_star_buf", kif.code, 16'h0012);
    key(3, 0);
    chk("star_kc", kif.key_code, 4'hE);
    chk("star_clr", {kif.code_len, kif.code}, 0);
    key(1, 2); key(0, 3);
    chk("letter_kc", kif.key_code, 4'hA);
    chk("letter_buf", kif.code, 16'h0006);
    chk("letter_len", kif.code_len, 1);
    key(3, 2);
    chk("hash6_rdy", kif.code_ready, 1);
    key(3, 0);
    chk("star_rdy_clr", {kif.code_ready, kif.code_len, kif.code}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
